// File: rtl/serial_parity_checker.sv
// Serial parity checker: shifts in DATA_W data bits (MSB first) plus one parity bit,
// then reports the parity error and the captured word. Optional error counter: SPC_ERR_CNT_EN.
module serial_parity_checker #(
    parameter int DATA_W    = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_mode,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              frame_clr,
    output logic              busy,
    output logic              done,
    output logic              pec,
    output logic [DATA_W-1:0] data_out
`ifdef SPC_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    // state | meaning
    // IDLE  | waiting for the first data bit of a frame
    // DATA  | collecting the remaining data bits
    // PAR   | waiting for the parity bit

    localparam int CNT_W = $clog2(DATA_W + 1);

    if (DATA_W < 1 || DATA_W > 32 || ERR_CNT_W < 1) begin : g_bad_param
        $error("serial_parity_checker: DATA_W must be 1..32 and ERR_CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_next;
    logic              mode;
    logic              err;

    // Shift expression stays legal for DATA_W=1, where no slice of shift exists.
    assign shift_next = (shift << 1) | DATA_W'(bit_in);
    assign err        = (^shift) ^ bit_in ^ mode;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            shift    <= '0;
            mode     <= 1'b0;
            done     <= 1'b0;
            pec      <= 1'b0;
            data_out <= '0;
`ifdef SPC_ERR_CNT_EN
            err_cnt  <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (frame_clr) begin
                state <= IDLE;
                cnt   <= '0;
                shift <= '0;
            end else if (bit_valid) begin
                unique case (state)
                    IDLE: begin
                        shift <= DATA_W'(bit_in);
                        cnt   <= CNT_W'(1);
                        mode  <= odd_mode;
                        state <= (DATA_W == 1) ? PAR : DATA;
                    end
                    DATA: begin
                        shift <= shift_next;
                        cnt   <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state <= PAR;
                        end
                    end
                    PAR: begin
                        done     <= 1'b1;
                        pec      <= err;
                        data_out <= shift;
                        cnt      <= '0;
                        shift    <= '0;
                        state    <= IDLE;
`ifdef SPC_ERR_CNT_EN
                        if (err && (err_cnt != '1)) begin
                            err_cnt <= err_cnt + ERR_CNT_W'(1);
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker (DATA_W=4): scoreboard of expected
// pec/data_out per frame, popped on each done pulse.
module tb_serial_parity_checker;

    localparam int DW = 4;
    localparam int EW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          odd_mode = 1'b0;
    logic          bit_valid = 1'b0;
    logic          bit_in = 1'b0;
    logic          frame_clr = 1'b0;
    logic          busy;
    logic          done;
    logic          pec;
    logic [DW-1:0] data_out;
`ifdef SPC_ERR_CNT_EN
    logic [EW-1:0] err_cnt;
    logic [EW-1:0] exp_cnt = '0;
`endif

    typedef struct packed {
        logic          pec;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic          last_pec  = 1'b0;
    logic [DW-1:0] last_data = '0;

    serial_parity_checker #(
        .DATA_W   (DW),
        .ERR_CNT_W(EW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .odd_mode (odd_mode),
        .bit_valid(bit_valid),
        .bit_in   (bit_in),
        .frame_clr(frame_clr),
        .busy     (busy),
        .done     (done),
        .pec      (pec),
        .data_out (data_out)
`ifdef SPC_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest pending frame.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pec", 32'(pec), 32'(e.pec));
                check("sb_data", 32'(data_out), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // mode1 applies to the first two bits, mode2 afterwards; only mode1 may matter.
    task automatic send_frame(input logic [DW-1:0] data, input logic p,
                              input logic mode1, input logic mode2, input int gap);
        exp_t e;
        for (int i = DW - 1; i >= 0; i--) begin
            odd_mode = (i >= DW - 2) ? mode1 : mode2;
            send_bit(data[i]);
            repeat (gap) tick();
            if (gap > 0) check("busy_gap", 32'(busy), 32'd1);
        end
        e.pec  = (^data) ^ p ^ mode1;
        e.data = data;
        exp_q.push_back(e);
        send_bit(p);
        check("done_latency", 32'(done), 32'd1);
        last_pec  = e.pec;
        last_data = data;
`ifdef SPC_ERR_CNT_EN
        if (e.pec && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pec"}, 32'(pec), 32'(last_pec));
        check({tag, "_data"}, 32'(data_out), 32'(last_data));
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_idle_outputs("reset");
`ifdef SPC_ERR_CNT_EN
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif

        send_frame(4'b0001, 1'b1, 1'b0, 1'b0, 0);
        tick();
        send_frame(4'b0001, 1'b0, 1'b0, 1'b0, 0);
        send_frame(4'b1100, 1'b0, 1'b0, 1'b0, 0);
        send_frame(4'b1011, 1'b0, 1'b1, 1'b1, 0);
        send_frame(4'b1011, 1'b0, 1'b1, 1'b0, 0);
        send_frame(4'b0110, 1'b1, 1'b1, 1'b1, 0);
        tick();
        check("done_pulse_width", 32'(done), 32'd0);

        // Gapped frames, second starting while done is high.
        send_frame(4'b1010, 1'b1, 1'b0, 1'b0, 3);
        send_frame(4'b1110, 1'b1, 1'b1, 1'b1, 3);
        tick();

        // Abort with a simultaneous valid bit.
        odd_mode = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        frame_clr = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        frame_clr = 1'b0;
        bit_valid = 1'b0;
        check_idle_outputs("frame_clr");
        tick();
        check_idle_outputs("frame_clr_hold");
        send_frame(4'b0111, 1'b0, 1'b0, 1'b0, 1);
        tick();

        // Reset mid-frame.
        send_bit(1'b1);
        send_bit(1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        last_pec  = 1'b0;
        last_data = '0;
        check_idle_outputs("rst_mid");
`ifdef SPC_ERR_CNT_EN
        exp_cnt = '0;
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        tick();
        check_idle_outputs("rst_hold");

        // Five errored frames then one clean one (saturation path when counting).
        for (int k = 0; k < 5; k++) begin
            send_frame(4'(k + 1), ~(^4'(k + 1)), 1'b0, 1'b0, 0);
        end
        send_frame(4'b1001, 1'b0, 1'b0, 1'b0, 0);
        tick();
        tick();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
Parametrised, serial-input parity checker. It assembles a frame of DATA_W data bits followed by one parity bit, then checks total parity in even or odd mode. It reports a registered error flag (pec) and the captured data word. It sits behind a bit-serial receiver and generalises the 4-bit combinational even-parity checker to arbitrary width, selectable mode and streamed input with gaps.

Parameters:
DATA_W, 4, data bits per frame; legal range 1..32.
ERR_CNT_W, 8, width of the saturating error counter. Used only when SPC_ERR_CNT_EN is defined.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  reset; one clock; reset is synchronous and active-low.
odd_mode  in  1  0 = even parity, 1 = odd parity; sampled on the first data bit of each frame.
bit_valid  in  1  bit_in is valid this cycle.
bit_in  in  1  serial bit; MSB of the data word first, parity bit last.
frame_clr  in  1  abort the current frame and return to IDLE.
busy  out  1  high while a frame is in progress (DATA or PAR).
done  out  1  one-cycle pulse when a frame completes.
pec  out  1  parity error of the last completed frame; held until the next done.
data_out  out  DATA_W  data word of the last completed frame; held until the next done.
err_cnt  out  ERR_CNT_W  saturating count of errored frames. Present only with SPC_ERR_CNT_EN.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; busy=0, done=0, pec=0, data_out=0, err_cnt=0; bit counter and shift register cleared. Reset mid-frame discards the frame with no done pulse.
- FSM states: IDLE, DATA, PAR.
  - IDLE: bit_valid=1 shifts bit_in into the shift register, sets bit count=1 and latches odd_mode. Goes to DATA, or to PAR if DATA_W=1.
  - DATA: each bit_valid=1 shifts bit_in in (shift left, LSB entry) and increments the count. When count reaches DATA_W, goes to PAR.
  - PAR: bit_valid=1 takes bit_in as parity bit p. err = (^shift) ^ p ^ mode_latched. Next cycle: done=1, pec=err, data_out=shift. Returns to IDLE.
- Resulting pec values: even mode gives pec=1 when the total ones count (data plus p) is odd. Odd mode gives pec=1 when the total is even.
- Latency: done, pec and data_out update exactly 1 cycle after the parity bit is accepted.
- Cycles with bit_valid=0 hold all state. Gaps of any length are legal in every state.
- busy=1 in DATA and PAR, and 0 in IDLE, all decoded from the registered state.
- frame_clr=1 at an edge: goes to IDLE, clears the count and shift register, produces no done, and leaves pec and data_out unchanged. It has priority over bit_valid in the same cycle; that bit is dropped. rst_n has priority over frame_clr.
- A new frame may start in IDLE on the same cycle that done is high. No idle gap is required between frames.
- odd_mode changes mid-frame have no effect; only the latched value is used.

Optional Feature:
Macro SPC_ERR_CNT_EN.
- Defined: err_cnt increments by 1 on every done with pec=1. It saturates at 2^ERR_CNT_W-1 and never wraps. It is cleared only by reset; frame_clr does not clear it.
- Not defined: the err_cnt port and its logic are absent, and all other behaviour is identical.

Test Plan:
- DATA_W=4, even mode, bits 0,0,0,1 then p=1 -> done pulse 1 cycle after p; pec=0, data_out=4'b0001.
- Same frame with p=0 -> pec=1. Then even mode, bits 1,1,0,0, p=0 -> pec=0.
- Odd mode, bits 1,0,1,1, p=0 -> pec=0. Change odd_mode to 0 after the 2nd bit -> still pec=0.
- Gaps and back-to-back: insert 3 idle cycles between every bit, and start a second frame on the cycle done is high -> both frames checked correctly.
- frame_clr after 2 data bits, together with bit_valid=1 -> no done, busy=0 next cycle, pec and data_out unchanged. A fresh frame then works. Repeat with rst_n=0 mid-frame -> all outputs 0.
- SPC_ERR_CNT_EN, ERR_CNT_W=2: 5 consecutive errored frames -> err_cnt sequence 1,2,3,3,3. A clean frame leaves it at 3.
